// File: rtl/ahb_lite_arbiter2.sv
// ---------------------------------------------------------------------------
// ahb_lite_arbiter2
//
// Two-master AHB-Lite arbiter in front of a single shared slave (the SDRAM
// controller). The address-phase owner is a registered grant that parks on
// the last owner. Ownership moves to the other master only when the current
// owner is idle (HTRANS IDLE or HSEL low), so bursts are never split. A
// separate registered data-phase owner routes HWDATA, HRESP and HREADY to
// the master whose transfer is in its data phase.
//
// Ports
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   M0_* / M1_*           master-side AHB-Lite address/control/data and
//                         responses (HRDATA broadcast, HREADY, HRESP)
//   S_*                   shared slave address/control/data and responses
//   GRANT                 current address-phase owner (0 = M0, 1 = M1)
//   M0_WAITCNT/M1_WAITCNT saturating count of cycles spent requesting
//                         without holding the grant
// ---------------------------------------------------------------------------
module ahb_lite_arbiter2 #(
  parameter int ADDR_W    = 32,
  parameter int WAITCNT_W = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,

  // Master 0
  input  logic [ADDR_W-1:0]    M0_HADDR,
  input  logic [2:0]           M0_HBURST,
  input  logic [2:0]           M0_HSIZE,
  input  logic [1:0]           M0_HTRANS,
  input  logic                 M0_HSEL,
  input  logic                 M0_HWRITE,
  input  logic [31:0]          M0_HWDATA,
  output logic [31:0]          M0_HRDATA,
  output logic                 M0_HREADY,
  output logic                 M0_HRESP,

  // Master 1
  input  logic [ADDR_W-1:0]    M1_HADDR,
  input  logic [2:0]           M1_HBURST,
  input  logic [2:0]           M1_HSIZE,
  input  logic [1:0]           M1_HTRANS,
  input  logic                 M1_HSEL,
  input  logic                 M1_HWRITE,
  input  logic [31:0]          M1_HWDATA,
  output logic [31:0]          M1_HRDATA,
  output logic                 M1_HREADY,
  output logic                 M1_HRESP,

  // Shared slave
  output logic [ADDR_W-1:0]    S_HADDR,
  output logic [2:0]           S_HBURST,
  output logic [2:0]           S_HSIZE,
  output logic [1:0]           S_HTRANS,
  output logic                 S_HSEL,
  output logic                 S_HWRITE,
  output logic [31:0]          S_HWDATA,
  input  logic [31:0]          S_HRDATA,
  input  logic                 S_HREADY,
  input  logic                 S_HRESP,

  // Status
  output logic                 GRANT,
  output logic [WAITCNT_W-1:0] M0_WAITCNT,
  output logic [WAITCNT_W-1:0] M1_WAITCNT
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  // The state encoding is the grant itself: PARK0 -> M0 owns, PARK1 -> M1.
  typedef enum logic {
    PARK0 = 1'b0,
    PARK1 = 1'b1
  } arb_state_t;

  arb_state_t           state;
  logic                 gnt;
  logic                 dph_own;
  logic                 dph_vld;
  logic [WAITCNT_W-1:0] m0_wait;
  logic [WAITCNT_W-1:0] m1_wait;

  logic req0, req1, req_gnt;
  logic m0_active, m1_active;

  assign gnt = state;

  // A request is a NONSEQ or SEQ transfer aimed at this slave.
  assign req0    = M0_HSEL & M0_HTRANS[1];
  assign req1    = M1_HSEL & M1_HTRANS[1];
  assign req_gnt = gnt ? req1 : req0;

  // "Active" also covers BUSY: a master inside a burst keeps the bus even
  // while it inserts BUSY beats.
  assign m0_active = M0_HSEL & (M0_HTRANS != HTRANS_IDLE);
  assign m1_active = M1_HSEL & (M1_HTRANS != HTRANS_IDLE);

  // -------------------------------------------------------------------------
  // Grant FSM and data-phase owner. Everything advances only on edges where
  // the slave accepts the current address phase.
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      state   <= PARK0;
      dph_own <= 1'b0;
      dph_vld <= 1'b0;
    end else if (S_HREADY) begin
      dph_own <= gnt;
      dph_vld <= req_gnt;
      case (state)
        PARK0:   if (!m0_active && req1) state <= PARK1;
        PARK1:   if (!m1_active && req0) state <= PARK0;
        default: state <= PARK0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Starvation counters: count every cycle a master requests without owning
  // the address phase, saturating instead of wrapping.
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m0_wait <= '0;
      m1_wait <= '0;
    end else begin
      if (req0 && gnt && (m0_wait != '1))
        m0_wait <= m0_wait + WAITCNT_W'(1);
      if (req1 && !gnt && (m1_wait != '1))
        m1_wait <= m1_wait + WAITCNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Address/control towards the slave follow the registered grant.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no
    // latch can be inferred.
    S_HADDR  = M0_HADDR;
    S_HBURST = M0_HBURST;
    S_HSIZE  = M0_HSIZE;
    S_HTRANS = M0_HTRANS;
    S_HSEL   = M0_HSEL;
    S_HWRITE = M0_HWRITE;
    if (gnt) begin
      S_HADDR  = M1_HADDR;
      S_HBURST = M1_HBURST;
      S_HSIZE  = M1_HSIZE;
      S_HTRANS = M1_HTRANS;
      S_HSEL   = M1_HSEL;
      S_HWRITE = M1_HWRITE;
    end
  end

  // Write data belongs to the transfer in its data phase.
  assign S_HWDATA = dph_own ? M1_HWDATA : M0_HWDATA;

  // Read data is broadcast; only the data-phase owner sees HREADY/HRESP
  // for it, so the other master ignores it.
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

  assign M0_HRESP = dph_vld & ~dph_own & S_HRESP;
  assign M1_HRESP = dph_vld &  dph_own & S_HRESP;

  // HREADY depends only on registered state and the slave, never on a
  // master's HTRANS. A master that neither owns the address phase nor the
  // data phase is stalled and holds its address. Both masters see ready
  // while in reset.
  assign M0_HREADY = ~HRESETn |
                     (S_HREADY & (~gnt | (dph_vld & ~dph_own)));
  assign M1_HREADY = ~HRESETn |
                     (S_HREADY & ( gnt | (dph_vld &  dph_own)));

  assign GRANT      = gnt;
  assign M0_WAITCNT = m0_wait;
  assign M1_WAITCNT = m1_wait;

endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_arbiter2
//
// Randomised stimulus against a cycle-level reference model of the arbiter's
// rules: who owns the address phase, which accepted address phase is in its
// data phase (kept as a history of accepted phases), and starvation counts
// kept as plain integers clamped to the counter maximum. Directed segments
// cover starvation/saturation, a slave wait during a pending switch, and a
// reset pulse while master 1 owns the bus mid-burst.
// ---------------------------------------------------------------------------
module tb_ahb_lite_arbiter2;

  localparam int AW     = 32;
  localparam int WW     = 4;
  localparam int WMAX   = (1 << WW) - 1;

  logic          HCLK;
  logic          HRESETn;

  // Master-side stimulus kept in arrays indexed by master number.
  logic [AW-1:0] m_addr  [2];
  logic [2:0]    m_burst [2];
  logic [2:0]    m_size  [2];
  logic [1:0]    m_trans [2];
  logic          m_sel   [2];
  logic          m_write [2];
  logic [31:0]   m_wdata [2];

  logic [31:0]   M0_HRDATA, M1_HRDATA;
  logic          M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [AW-1:0] S_HADDR;
  logic [2:0]    S_HBURST, S_HSIZE;
  logic [1:0]    S_HTRANS;
  logic          S_HSEL, S_HWRITE;
  logic [31:0]   S_HWDATA;
  logic [31:0]   S_HRDATA;
  logic          S_HREADY, S_HRESP;
  logic          GRANT;
  logic [WW-1:0] M0_WAITCNT, M1_WAITCNT;

  ahb_lite_arbiter2 #(.ADDR_W(AW), .WAITCNT_W(WW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .M0_HADDR   (m_addr[0]),
    .M0_HBURST  (m_burst[0]),
    .M0_HSIZE   (m_size[0]),
    .M0_HTRANS  (m_trans[0]),
    .M0_HSEL    (m_sel[0]),
    .M0_HWRITE  (m_write[0]),
    .M0_HWDATA  (m_wdata[0]),
    .M0_HRDATA  (M0_HRDATA),
    .M0_HREADY  (M0_HREADY),
    .M0_HRESP   (M0_HRESP),
    .M1_HADDR   (m_addr[1]),
    .M1_HBURST  (m_burst[1]),
    .M1_HSIZE   (m_size[1]),
    .M1_HTRANS  (m_trans[1]),
    .M1_HSEL    (m_sel[1]),
    .M1_HWRITE  (m_write[1]),
    .M1_HWDATA  (m_wdata[1]),
    .M1_HRDATA  (M1_HRDATA),
    .M1_HREADY  (M1_HREADY),
    .M1_HRESP   (M1_HRESP),
    .S_HADDR    (S_HADDR),
    .S_HBURST   (S_HBURST),
    .S_HSIZE    (S_HSIZE),
    .S_HTRANS   (S_HTRANS),
    .S_HSEL     (S_HSEL),
    .S_HWRITE   (S_HWRITE),
    .S_HWDATA   (S_HWDATA),
    .S_HRDATA   (S_HRDATA),
    .S_HREADY   (S_HREADY),
    .S_HRESP    (S_HRESP),
    .GRANT      (GRANT),
    .M0_WAITCNT (M0_WAITCNT),
    .M1_WAITCNT (M1_WAITCNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------------
  typedef struct {
    int m;        // master whose address phase was accepted
    bit xfer;     // that address phase carried a real transfer
  } phase_t;

  int     owner;
  int     wait_cnt [2];
  phase_t accepted [$];
  int     burst_left [2];

  function automatic bit wants(input int m);
    return m_sel[m] && m_trans[m][1];
  endfunction

  function automatic bit in_burst(input int m);
    return m_sel[m] && (m_trans[m] != 2'b00);
  endfunction

  task automatic model_reset();
    owner = 0;
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
    accepted.delete();
  endtask

  // Applies the arbitration rules for one rising edge.
  task automatic model_edge();
    int other;
    if (!HRESETn) return;
    for (int m = 0; m < 2; m++)
      if (wants(m) && owner != m)
        wait_cnt[m] = (wait_cnt[m] + 1 > WMAX) ? WMAX : wait_cnt[m] + 1;
    if (S_HREADY) begin
      accepted.push_back('{m: owner, xfer: wants(owner)});
      if (accepted.size() > 4) void'(accepted.pop_front());
      other = 1 - owner;
      if (!in_burst(owner) && wants(other)) owner = other;
    end
  endtask

  task automatic check_outputs();
    int dm;
    bit dv;
    logic exp_rdy, exp_rsp;
    dm = 0;
    dv = 1'b0;
    if (accepted.size() != 0) begin
      dm = accepted[$].m;
      dv = accepted[$].xfer;
    end
    check("grant",   64'(GRANT),    64'(owner));
    check("s_haddr", 64'(S_HADDR),  64'(m_addr[owner]));
    check("s_ctl",   64'({S_HBURST, S_HSIZE, S_HTRANS, S_HSEL, S_HWRITE}),
          64'({m_burst[owner], m_size[owner], m_trans[owner],
               m_sel[owner], m_write[owner]}));
    check("s_hwdata", 64'(S_HWDATA), 64'(m_wdata[dm]));
    check("m0_hrdata", 64'(M0_HRDATA), 64'(S_HRDATA));
    check("m1_hrdata", 64'(M1_HRDATA), 64'(S_HRDATA));
    for (int m = 0; m < 2; m++) begin
      exp_rdy = !HRESETn ? 1'b1
                         : (S_HREADY && (owner == m || (dv && dm == m)));
      exp_rsp = (HRESETn && dv && dm == m) ? S_HRESP : 1'b0;
      if (m == 0) begin
        check("m0_hready",  64'(M0_HREADY),  64'(exp_rdy));
        check("m0_hresp",   64'(M0_HRESP),   64'(exp_rsp));
        check("m0_waitcnt", 64'(M0_WAITCNT), 64'(wait_cnt[0]));
      end else begin
        check("m1_hready",  64'(M1_HREADY),  64'(exp_rdy));
        check("m1_hresp",   64'(M1_HRESP),   64'(exp_rsp));
        check("m1_waitcnt", 64'(M1_WAITCNT), 64'(wait_cnt[1]));
      end
    end
  endtask

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  localparam int MODE_RANDOM  = 0;
  localparam int MODE_M0_TAKE = 1; // M1 deselected, M0 starts a transfer
  localparam int MODE_STARVE  = 2; // M0 keeps bursting, M1 requests
  localparam int MODE_SWAIT   = 3; // M0 idle, M1 requests, slave stalls
  localparam int MODE_M1_SEQ  = 4; // M0 deselected, M1 bursting
  localparam int MODE_BOTH    = 5; // both request NONSEQ

  task automatic set_master(input int m, input logic sel,
                            input logic [1:0] trans);
    m_sel[m]   = sel;
    m_trans[m] = trans;
    m_addr[m]  = $urandom;
    m_burst[m] = 3'($urandom_range(7));
    m_size[m]  = 3'($urandom_range(2));
    m_write[m] = 1'($urandom_range(1));
    m_wdata[m] = $urandom;
  endtask

  task automatic random_master(input int m);
    int r;
    if (burst_left[m] > 0) begin
      burst_left[m]--;
      set_master(m, 1'b1, ($urandom_range(3) == 0) ? 2'b01 : 2'b11);
    end else begin
      r = $urandom_range(9);
      if (r < 4) begin
        set_master(m, 1'($urandom_range(1)), 2'b00);
      end else if (r < 8) begin
        set_master(m, 1'b1, 2'b10);
        burst_left[m] = $urandom_range(5);
      end else begin
        set_master(m, 1'b0, 2'($urandom_range(3)));
      end
    end
  endtask

  task automatic apply(input int mode);
    S_HRDATA = $urandom;
    S_HRESP  = 1'($urandom_range(1));
    S_HREADY = 1'b1;
    case (mode)
      MODE_M0_TAKE: begin
        set_master(0, 1'b1, 2'b10);
        set_master(1, 1'b0, 2'b00);
      end
      MODE_STARVE: begin
        set_master(0, 1'b1, ($urandom_range(1) == 0) ? 2'b10 : 2'b11);
        set_master(1, 1'b1, 2'b10);
      end
      MODE_SWAIT: begin
        set_master(0, 1'b1, 2'b00);
        set_master(1, 1'b1, 2'b10);
        S_HREADY = 1'b0;
      end
      MODE_M1_SEQ: begin
        set_master(0, 1'b0, 2'b00);
        set_master(1, 1'b1, 2'b11);
      end
      MODE_BOTH: begin
        set_master(0, 1'b1, 2'b10);
        set_master(1, 1'b1, 2'b10);
      end
      default: begin
        random_master(0);
        random_master(1);
        S_HREADY = ($urandom_range(3) != 0);
      end
    endcase
  endtask

  // One clock cycle: new inputs after the falling edge, outputs checked
  // mid-low-phase, model advanced at the rising edge.
  task automatic step(input int mode, input logic rst_val);
    @(negedge HCLK);
    HRESETn = rst_val;
    if (!rst_val) model_reset();
    apply(mode);
    #1;
    check_outputs();
    @(posedge HCLK);
    model_edge();
  endtask

  initial begin
    HRESETn = 1'b0;
    for (int m = 0; m < 2; m++) begin
      set_master(m, 1'b0, 2'b00);
      burst_left[m] = 0;
    end
    S_HRDATA = '0;
    S_HREADY = 1'b1;
    S_HRESP  = 1'b0;
    model_reset();

    // Reset state with random inputs.
    for (int i = 0; i < 3; i++) step(MODE_RANDOM, 1'b0);

    for (int i = 0; i < 1500; i++) step(MODE_RANDOM, 1'b1);

    // Starvation of M1 behind a continuous M0 burst: counter saturates.
    for (int i = 0; i < 3; i++)  step(MODE_M0_TAKE, 1'b1);
    for (int i = 0; i < 20; i++) step(MODE_STARVE, 1'b1);
    #1;
    check("sat_m1_waitcnt", 64'(M1_WAITCNT), 64'(WMAX));
    check("sat_grant",      64'(GRANT),      64'(0));
    for (int i = 0; i < 3; i++)  step(MODE_STARVE, 1'b1);

    // Slave wait during a pending switch: grant must not move.
    for (int i = 0; i < 3; i++) step(MODE_M0_TAKE, 1'b1);
    for (int i = 0; i < 5; i++) step(MODE_SWAIT, 1'b1);
    #1;
    check("swait_grant", 64'(GRANT), 64'(0));
    step(MODE_BOTH, 1'b1);
    step(MODE_M1_SEQ, 1'b1);

    // Reset while M1 owns the bus in the middle of a burst.
    for (int i = 0; i < 3; i++) step(MODE_M1_SEQ, 1'b1);
    for (int i = 0; i < 2; i++) step(MODE_M1_SEQ, 1'b0);
    for (int i = 0; i < 3; i++) step(MODE_BOTH, 1'b1);

    for (int i = 0; i < 1000; i++) step(MODE_RANDOM, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arbiter2.md
AHB_LITE_ARBITER2 -- requirements
Module: ahb_lite_arbiter2

Interface
REQ-001 Parameter ADDR_W, default 32, HADDR width on all ports.
REQ-002 Parameter WAITCNT_W, default 16, width of per-master wait counters.
REQ-003 HCLK  in  1  single clock; all state updates on rising edge.
REQ-004 HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 M0_HADDR/M1_HADDR  in  ADDR_W  master address.
REQ-006 M0_/M1_ HBURST, HSIZE  in  3 each; HTRANS  in  2; HSEL, HWRITE  in  1; HWDATA  in  32  master controls and write data.
REQ-007 M0_/M1_ HRDATA  out  32; HREADY  out  1; HRESP  out  1  master responses.
REQ-008 S_HADDR, S_HBURST, S_HSIZE, S_HTRANS, S_HSEL, S_HWRITE, S_HWDATA  out  (widths as masters)  to the single shared slave (the SDRAM controller).
REQ-009 S_HRDATA  in  32; S_HREADY  in  1; S_HRESP  in  1  slave response.
REQ-010 GRANT  out  1  current address-phase owner (0 = M0, 1 = M1).
REQ-011 M0_WAITCNT/M1_WAITCNT  out  WAITCNT_W  saturating count of cycles spent requesting without grant.

Function
REQ-012 Request from master m SHALL be req_m = Mm_HSEL & Mm_HTRANS[1] (NONSEQ or SEQ).
REQ-013 Registered grant gnt SHALL select which master's address/control drives S_* combinationally.
REQ-014 Registered data-phase owner dph_own plus valid flag dph_vld SHALL be loaded from gnt and req_gnt on every rising edge with S_HREADY=1; held while S_HREADY=0.
REQ-015 S_HWDATA SHALL be muxed by dph_own; S_HRDATA SHALL be broadcast to both M*_HRDATA.
REQ-016 Mm_HRESP SHALL equal S_HRESP when dph_vld & dph_own==m, else 0.
REQ-017 Mm_HREADY SHALL equal S_HREADY when gnt==m or (dph_vld & dph_own==m), else 0 (non-owner stalled, holds its address phase).
REQ-018 Arbiter states: PARK0, PARK1 (gnt encoded directly); transitions only on edges with S_HREADY=1.
REQ-019 Switch gnt m -> other SHALL occur only when owner presents HTRANS IDLE or HSEL=0 in the current address phase and other master requests; never during NONSEQ/SEQ/BUSY of owner (bursts never split).
REQ-020 Neither requesting: gnt SHALL stay parked on last owner.
REQ-021 Both requesting with owner IDLE: switch to the other master (round-robin).
REQ-022 Switch latency: waiting master's address SHALL appear on S_HADDR in the cycle after the owner's IDLE cycle is accepted (exactly one IDLE bubble on slave).
REQ-023 Mm_WAITCNT SHALL increment each cycle req_m=1 and gnt!=m; saturate at all-ones; never cleared except by reset.
REQ-024 S_HREADY=0 during a switch condition SHALL defer the switch until the edge where S_HREADY=1.
REQ-025 No combinational path SHALL exist from Mm_HTRANS to Mm_HREADY.

Reset
REQ-026 HRESETn low SHALL immediately set gnt=0, dph_vld=0, dph_own=0, both WAITCNT=0.
REQ-027 While HRESETn low, M0_HREADY and M1_HREADY SHALL both be 1 and both HRESP 0.
REQ-028 Reset asserted mid-burst SHALL abort arbitration state; after release M0 is owner regardless of prior gnt.

Verification
REQ-029 Single master: M0 writes 0x12345678 to 0x1, reads back with M1 idle -> GRANT stays 0, read data 0x12345678, M1_WAITCNT=0.
REQ-030 Contention: M0 issues WRAP4 write while M1 requests NONSEQ at burst beat 2 -> all 4 M0 beats complete uninterrupted, M1_HREADY=0 throughout, GRANT=1 one cycle after M0 IDLE, M1 address on S_HADDR next cycle.
REQ-031 Alternation: two ahb_lite_rw_master instances (disjoint address ranges, IDLE between transfers) against ahb_lite_sdram for 70 us -> both report S_SUCCESS, ERRCOUNT=0.
REQ-032 Slave wait: S_HREADY held 0 for 5 cycles during M0 data phase with M1 requesting and M0 IDLE -> no switch until S_HREADY=1; M1_WAITCNT increases by >=5.
REQ-033 Saturation: WAITCNT_W=4, M1 starved 20 cycles -> M1_WAITCNT=15 and holds.
REQ-034 Reset mid-transfer: HRESETn pulsed low while GRANT=1 during M1 SEQ beat -> GRANT=0, both HREADY=1 during reset, M0 transfer accepted first after release.
